// File: rtl/bloom_scan_ctrl_if.sv
// Core-facing request/result wires and the host result handshake of the
// bloom scan sequencer, grouped so the controller and its environment share one bundle.
interface bloom_scan_ctrl_if #(
  parameter int BLK_IDX_WIDTH = 3,
  parameter int DIST_WIDTH    = 14
);
  logic [1:0]               core_mode;
  logic [DIST_WIDTH-1:0]    core_distance;
  logic                     core_ref_end;
  logic                     core_bloom_end;
  logic                     core_contains_ref;
  logic [DIST_WIDTH-1:0]    core_ref_dist;
  logic                     core_contains_bloom;
  logic                     res_valid;
  logic                     res_ready;
  logic [BLK_IDX_WIDTH-1:0] res_blk_idx;
  logic                     res_has_ref;
  logic [DIST_WIDTH-1:0]    res_ref_dist;
  logic                     res_bloom_new;

  modport master (
    output core_mode, core_distance,
    input  core_ref_end, core_bloom_end, core_contains_ref, core_ref_dist, core_contains_bloom,
    output res_valid, res_blk_idx, res_has_ref, res_ref_dist, res_bloom_new,
    input  res_ready
  );

  modport slave (
    input  core_mode, core_distance,
    output core_ref_end, core_bloom_end, core_contains_ref, core_ref_dist, core_contains_bloom,
    input  res_valid, res_blk_idx, res_has_ref, res_ref_dist, res_bloom_new,
    output res_ready
  );
endinterface

// File: rtl/bloom_scan_ctrl.sv
// Sequences one reference pass and one blooming pass per block through the scan
// core, feeding the captured reference distance back and reporting one record per block.
module bloom_scan_ctrl #(
  parameter int BLOCK_NUM     = 8,
  parameter int BLK_IDX_WIDTH = 3,
  parameter int DIST_WIDTH    = 14,
  parameter int TIMEOUT       = 40,
  parameter int TO_WIDTH      = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic [BLK_IDX_WIDTH-1:0] blk_idx,
  bloom_scan_ctrl_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REF_REQ  = 3'd1,
    S_REF_WAIT = 3'd2,
    S_BLM_REQ  = 3'd3,
    S_BLM_WAIT = 3'd4,
    S_REPORT   = 3'd5,
    S_NEXT     = 3'd6
  } state_e;

  localparam logic [1:0]               MODE_NONE = 2'b00;
  localparam logic [1:0]               MODE_REF  = 2'b01;
  localparam logic [1:0]               MODE_BLM  = 2'b10;
  localparam logic [BLK_IDX_WIDTH-1:0] BLK_ZERO  = {BLK_IDX_WIDTH{1'b0}};
  localparam logic [BLK_IDX_WIDTH-1:0] BLK_ONE   = BLK_IDX_WIDTH'(1'b1);
  localparam logic [BLK_IDX_WIDTH-1:0] BLK_LAST  = BLK_IDX_WIDTH'(BLOCK_NUM - 1);
  localparam logic [TO_WIDTH-1:0]      TO_ZERO   = {TO_WIDTH{1'b0}};
  localparam logic [TO_WIDTH-1:0]      TO_ONE    = TO_WIDTH'(1'b1);
  localparam logic [TO_WIDTH-1:0]      TO_LAST   = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [DIST_WIDTH-1:0]    DIST_ZERO = {DIST_WIDTH{1'b0}};

  state_e                   state_r;
  state_e                   next_state_s;
  logic                     start_acc_s;
  logic                     abort_s;
  logic                     finish_s;
  logic                     last_blk_s;
  logic                     to_expire_s;
  logic                     handshake_s;
  logic [TO_WIDTH-1:0]      to_cnt_r;
  logic [BLK_IDX_WIDTH-1:0] blk_idx_r;
  logic [DIST_WIDTH-1:0]    ref_dist_r;
  logic                     has_ref_r;
  logic                     bloom_before_r;
  logic                     bloom_new_r;
  logic [1:0]               core_mode_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     err_timeout_r;
  logic                     res_valid_r;

  // Next-state decode; an end strobe wins over a timeout expiring in the same cycle.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    start_acc_s  = (state_r == S_IDLE) && start;
    last_blk_s   = (blk_idx_r == BLK_LAST);
    to_expire_s  = (to_cnt_r == TO_LAST);
    handshake_s  = res_valid_r && bus.res_ready;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_REF_REQ;
        else       next_state_s = S_IDLE;
      end
      S_REF_REQ: next_state_s = S_REF_WAIT;
      S_REF_WAIT: begin
        if (bus.core_ref_end) begin
          if (bus.core_contains_ref) next_state_s = S_BLM_REQ;
          else                       next_state_s = S_REPORT;
        end else if (to_expire_s) begin
          next_state_s = S_IDLE;
          abort_s      = 1'b1;
        end else begin
          next_state_s = S_REF_WAIT;
        end
      end
      S_BLM_REQ: next_state_s = S_BLM_WAIT;
      S_BLM_WAIT: begin
        if (bus.core_bloom_end) begin
          next_state_s = S_REPORT;
        end else if (to_expire_s) begin
          next_state_s = S_IDLE;
          abort_s      = 1'b1;
        end else begin
          next_state_s = S_BLM_WAIT;
        end
      end
      S_REPORT: begin
        if (handshake_s) next_state_s = S_NEXT;
        else             next_state_s = S_REPORT;
      end
      S_NEXT: begin
        if (last_blk_s) next_state_s = S_IDLE;
        else            next_state_s = S_REF_REQ;
      end
      default: next_state_s = S_IDLE;
    endcase
    finish_s = (next_state_s == S_NEXT) && last_blk_s;
  end

  // State register and outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      core_mode_r   <= MODE_NONE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      res_valid_r   <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      // Request modes are one-cycle pulses; the core restarts if mode is held.
      core_mode_r <= (next_state_s == S_REF_REQ) ? MODE_REF :
                     (next_state_s == S_BLM_REQ) ? MODE_BLM : MODE_NONE;
      busy_r      <= (next_state_s != S_IDLE) && !finish_s;
      done_r      <= finish_s || abort_s;
      res_valid_r <= (next_state_s == S_REPORT);
      if (abort_s)          err_timeout_r <= 1'b1;
      else if (start_acc_s) err_timeout_r <= 1'b0;
      else                  err_timeout_r <= err_timeout_r;
    end
  end

  // Block index and the per-WAIT timeout counter, restarted on each WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_idx_r <= BLK_ZERO;
      to_cnt_r  <= TO_ZERO;
    end else begin
      if (start_acc_s)                         blk_idx_r <= BLK_ZERO;
      else if (state_r == S_NEXT && !last_blk_s) blk_idx_r <= blk_idx_r + BLK_ONE;
      else                                     blk_idx_r <= blk_idx_r;
      if ((next_state_s == S_REF_WAIT || next_state_s == S_BLM_WAIT) && next_state_s == state_r)
        to_cnt_r <= to_cnt_r + TO_ONE;
      else
        to_cnt_r <= TO_ZERO;
    end
  end

  // Capture of core results; they are only valid in the strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      has_ref_r      <= 1'b0;
      ref_dist_r     <= DIST_ZERO;
      bloom_before_r <= 1'b0;
      bloom_new_r    <= 1'b0;
    end else begin
      if (next_state_s == S_REF_REQ) begin
        has_ref_r   <= 1'b0;
        ref_dist_r  <= DIST_ZERO;
        bloom_new_r <= 1'b0;
      end else if (state_r == S_REF_WAIT && bus.core_ref_end) begin
        has_ref_r  <= bus.core_contains_ref;
        ref_dist_r <= bus.core_contains_ref ? bus.core_ref_dist : DIST_ZERO;
      end else if (state_r == S_BLM_WAIT && bus.core_bloom_end) begin
        // The core flag is cumulative, so only a rise during this pass counts.
        bloom_new_r <= bus.core_contains_bloom && !bloom_before_r;
      end else begin
        has_ref_r   <= has_ref_r;
        ref_dist_r  <= ref_dist_r;
        bloom_new_r <= bloom_new_r;
      end
      if (state_r == S_BLM_REQ) bloom_before_r <= bus.core_contains_bloom;
      else                      bloom_before_r <= bloom_before_r;
    end
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign err_timeout       = err_timeout_r;
  assign blk_idx           = blk_idx_r;
  assign bus.core_mode     = core_mode_r;
  assign bus.core_distance = ref_dist_r;
  assign bus.res_valid     = res_valid_r;
  assign bus.res_blk_idx   = blk_idx_r;
  assign bus.res_has_ref   = has_ref_r;
  assign bus.res_ref_dist  = ref_dist_r;
  assign bus.res_bloom_new = bloom_new_r;

endmodule

// File: tb/tb_bloom_scan_ctrl.sv
// Directed bench: instance 0 scans one block, instance 1 scans three; a small
// core model answers every request with its end strobe 30 cycles later.
module tb_bloom_scan_ctrl;
  localparam int BW = 3;
  localparam int DW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s [2];
  logic busy_s [2];
  logic done_s [2];
  logic err_s [2];
  logic [BW-1:0] blk_s [2];
  logic [1:0] mode_s [2];
  logic [DW-1:0] cdist_s [2];
  logic rvalid_s [2];
  logic rready_s [2];
  logic [BW-1:0] ridx_s [2];
  logic rhas_s [2];
  logic [DW-1:0] rdist_s [2];
  logic rbnew_s [2];

  logic cfg_has_ref [2];
  logic cfg_hang [2];
  logic [DW-1:0] cfg_dist [2];
  logic [7:0] cfg_bloom [2];

  int checks = 0;
  int errors = 0;

  int done_at, n_done, n_m10, n_long, n_unstable, n_busy_low, ready_rise;
  int ref_req_at [$];
  logic [BW-1:0] req_blk [$];
  logic [BW-1:0] rec_idx [$];
  logic rec_has [$];
  logic [DW-1:0] rec_dist [$];
  logic rec_bnew [$];
  logic [DW-1:0] blm_dist [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    bloom_scan_ctrl_if #(.BLK_IDX_WIDTH(BW), .DIST_WIDTH(DW)) bus ();
    int ref_cnt;
    int blm_cnt;
    logic bloom_r;

    bloom_scan_ctrl #(
      .BLOCK_NUM(g == 0 ? 1 : 3), .BLK_IDX_WIDTH(BW), .DIST_WIDTH(DW),
      .TIMEOUT(40), .TO_WIDTH(6)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_s[g]), .busy(busy_s[g]),
      .done(done_s[g]), .err_timeout(err_s[g]), .blk_idx(blk_s[g]), .bus(bus)
    );

    // Core model: end strobe 30 cycles after the request cycle.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ref_cnt <= 0;
        blm_cnt <= 0;
        bloom_r <= 1'b0;
        bus.core_ref_end <= 1'b0;
        bus.core_bloom_end <= 1'b0;
        bus.core_contains_ref <= 1'b0;
        bus.core_ref_dist <= '0;
      end else begin
        bus.core_ref_end <= 1'b0;
        bus.core_bloom_end <= 1'b0;
        bus.core_contains_ref <= 1'b0;
        bus.core_ref_dist <= '0;
        if (bus.core_mode == 2'b01 && !cfg_hang[g]) ref_cnt <= 29;
        else if (ref_cnt != 0) begin
          ref_cnt <= ref_cnt - 1;
          if (ref_cnt == 1) begin
            bus.core_ref_end <= 1'b1;
            bus.core_contains_ref <= cfg_has_ref[g];
            bus.core_ref_dist <= cfg_dist[g];
          end
        end
        if (bus.core_mode == 2'b10) blm_cnt <= 29;
        else if (blm_cnt != 0) begin
          blm_cnt <= blm_cnt - 1;
          if (blm_cnt == 1) begin
            bus.core_bloom_end <= 1'b1;
            bloom_r <= bloom_r | cfg_bloom[g][blk_s[g]];
          end
        end
      end
    end

    assign bus.core_contains_bloom = bloom_r;
    assign bus.res_ready = rready_s[g];
    assign mode_s[g]  = bus.core_mode;
    assign cdist_s[g] = bus.core_distance;
    assign rvalid_s[g] = bus.res_valid;
    assign ridx_s[g]  = bus.res_blk_idx;
    assign rhas_s[g]  = bus.res_has_ref;
    assign rdist_s[g] = bus.res_ref_dist;
    assign rbnew_s[g] = bus.res_bloom_new;
  end

  function automatic logic [41:0] outs_of(input int g);
    return {busy_s[g], done_s[g], err_s[g], blk_s[g], mode_s[g], cdist_s[g],
            rvalid_s[g], ridx_s[g], rhas_s[g], rdist_s[g], rbnew_s[g]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0;
      rready_s[g] = 1'b0;
      cfg_has_ref[g] = 1'b0;
      cfg_hang[g] = 1'b0;
      cfg_dist[g] = '0;
      cfg_bloom[g] = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one scan on instance g from a start pulse; hold = ready-low cycles per record.
  task automatic run_scan(input int g, input int hold, input int extra_start, input int max_cyc);
    int held, stop_at;
    logic [1:0] pm;
    logic pv, pr;
    logic [BW+DW+1:0] pf, f;
    done_at = -1; n_done = 0; n_m10 = 0; n_long = 0; n_unstable = 0;
    n_busy_low = 0; ready_rise = -1;
    ref_req_at.delete(); req_blk.delete(); rec_idx.delete(); rec_has.delete();
    rec_dist.delete(); rec_bnew.delete(); blm_dist.delete();
    pm = 2'b00; pv = 1'b0; pr = 1'b0; pf = '0; held = 0; stop_at = max_cyc;
    rready_s[g] = (hold == 0);
    @(negedge clk); start_s[g] = 1'b1;
    @(negedge clk); start_s[g] = 1'b0;
    for (int cyc = 1; cyc <= stop_at; cyc++) begin
      start_s[g] = (cyc == extra_start);
      f = {ridx_s[g], rhas_s[g], rdist_s[g], rbnew_s[g]};
      if (mode_s[g] != 2'b00 && pm != 2'b00) n_long++;
      if (mode_s[g] == 2'b10) begin n_m10++; blm_dist.push_back(cdist_s[g]); end
      if (mode_s[g] == 2'b01) begin ref_req_at.push_back(cyc); req_blk.push_back(blk_s[g]); end
      if (pv && !pr && (!rvalid_s[g] || f !== pf)) n_unstable++;
      if (done_s[g]) begin
        n_done++;
        if (done_at < 0) begin done_at = cyc; stop_at = cyc + 4; end
      end
      if (done_at < 0 && !busy_s[g]) n_busy_low++;
      if (rvalid_s[g]) begin
        if (held < hold) begin rready_s[g] = 1'b0; held++; end
        else begin
          if (!rready_s[g] && ready_rise < 0) ready_rise = cyc;
          rready_s[g] = 1'b1;
        end
        if (rready_s[g]) begin
          rec_idx.push_back(ridx_s[g]); rec_has.push_back(rhas_s[g]);
          rec_dist.push_back(rdist_s[g]); rec_bnew.push_back(rbnew_s[g]);
          held = 0;
        end
      end else if (hold > 0) rready_s[g] = 1'b0;
      pm = mode_s[g]; pv = rvalid_s[g]; pr = rready_s[g]; pf = f;
      @(negedge clk);
    end
    start_s[g] = 1'b0;
    checks++;
    if (done_at < 0) begin errors++; $display("FAIL scan_bound inst %0d: no done within %0d cycles", g, max_cyc); end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (outs_of(g) !== '0) begin errors++; $display("FAIL reset_state inst %0d: got %h want 0", g, outs_of(g)); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    do_reset();
    cfg_has_ref[0] = 1'b1; cfg_dist[0] = 14'h0123; cfg_bloom[0] = 8'h01;
    run_scan(0, 0, -1, 200);
    checks++;
    if (done_at != 64) begin errors++; $display("FAIL single_done_at: got %0d want 64", done_at); end
    checks++;
    if (rec_idx.size() != 1 || {rec_idx[0], rec_has[0], rec_dist[0], rec_bnew[0]} !== {3'd0, 1'b1, 14'h0123, 1'b1}) begin
      errors++; $display("FAIL single_record: got n=%0d idx=%0d has=%0b dist=%h bnew=%0b want n=1 0 1 0123 1",
                         rec_idx.size(), rec_idx[0], rec_has[0], rec_dist[0], rec_bnew[0]);
    end
    checks++;
    if (blm_dist.size() != 1 || blm_dist[0] !== 14'h0123) begin
      errors++; $display("FAIL single_core_distance: got n=%0d dist=%h want n=1 0123", blm_dist.size(), blm_dist[0]);
    end
    checks++;
    if (n_long != 0 || n_m10 != 1 || ref_req_at.size() != 1) begin
      errors++; $display("FAIL single_mode_pulses: got long=%0d m10=%0d m01=%0d want 0 1 1", n_long, n_m10, ref_req_at.size());
    end
    checks++;
    if (n_busy_low != 0 || n_done != 1 || busy_s[0] !== 1'b0) begin
      errors++; $display("FAIL single_busy_done: got busy_low=%0d done_n=%0d busy=%0b want 0 1 0", n_busy_low, n_done, busy_s[0]);
    end
  endtask

  task automatic test_no_ref();
    do_reset();
    cfg_has_ref[0] = 1'b0; cfg_dist[0] = 14'h00AB;
    run_scan(0, 0, -1, 200);
    checks++;
    if (n_m10 != 0) begin errors++; $display("FAIL noref_mode10: got %0d cycles want 0", n_m10); end
    checks++;
    if (rec_idx.size() != 1 || {rec_idx[0], rec_has[0], rec_dist[0], rec_bnew[0]} !== '0) begin
      errors++; $display("FAIL noref_record: got n=%0d has=%0b dist=%h bnew=%0b want n=1 0 0 0",
                         rec_idx.size(), rec_has[0], rec_dist[0], rec_bnew[0]);
    end
    checks++;
    if (done_at != 33) begin errors++; $display("FAIL noref_done_at: got %0d want 33", done_at); end
  endtask

  task automatic test_sticky_bloom();
    do_reset();
    cfg_has_ref[1] = 1'b1; cfg_dist[1] = 14'h1ABC; cfg_bloom[1] = 8'h02;
    run_scan(1, 0, 100, 400);
    checks++;
    if (rec_bnew.size() != 3 || {rec_bnew[0], rec_bnew[1], rec_bnew[2]} !== 3'b010) begin
      errors++; $display("FAIL sticky_bloom_new: got n=%0d %0b%0b%0b want 3 010", rec_bnew.size(), rec_bnew[0], rec_bnew[1], rec_bnew[2]);
    end
    checks++;
    if (rec_idx.size() != 3 || {rec_idx[0], rec_idx[1], rec_idx[2]} !== {3'd0, 3'd1, 3'd2} ||
        req_blk.size() != 3 || {req_blk[0], req_blk[1], req_blk[2]} !== {3'd0, 3'd1, 3'd2}) begin
      errors++; $display("FAIL sticky_blk_idx: got rec %0d,%0d,%0d req %0d,%0d,%0d want 0,1,2",
                         rec_idx[0], rec_idx[1], rec_idx[2], req_blk[0], req_blk[1], req_blk[2]);
    end
    checks++;
    if (ref_req_at.size() != 3 || ref_req_at[0] != 1 || ref_req_at[1] != 65 || ref_req_at[2] != 129) begin
      errors++; $display("FAIL sticky_req_times: got %0d,%0d,%0d want 1,65,129", ref_req_at[0], ref_req_at[1], ref_req_at[2]);
    end
    checks++;
    if (n_done != 1 || done_at != 192 || n_long != 0 || n_m10 != 3) begin
      errors++; $display("FAIL sticky_done: got n=%0d at=%0d long=%0d m10=%0d want 1 192 0 3", n_done, done_at, n_long, n_m10);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cfg_has_ref[1] = 1'b1; cfg_dist[1] = 14'h0777;
    run_scan(1, 10, -1, 400);
    checks++;
    if (ready_rise != 73 || ref_req_at.size() < 2 || ref_req_at[1] != ready_rise + 2) begin
      errors++; $display("FAIL bp_next_req: got rise=%0d req1=%0d want 73 75", ready_rise, ref_req_at[1]);
    end
    checks++;
    if (n_unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", n_unstable); end
    checks++;
    if (rec_dist.size() != 3 || rec_dist[2] !== 14'h0777 || done_at != 222) begin
      errors++; $display("FAIL bp_records: got n=%0d dist=%h done_at=%0d want 3 0777 222", rec_dist.size(), rec_dist[2], done_at);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_hang[0] = 1'b1; cfg_has_ref[0] = 1'b1;
    run_scan(0, 0, -1, 200);
    checks++;
    if (done_at != 42 || n_done != 1) begin errors++; $display("FAIL to_done: got at=%0d n=%0d want 42 1", done_at, n_done); end
    checks++;
    if (err_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || rec_idx.size() != 0 || n_m10 != 0) begin
      errors++; $display("FAIL to_state: got err=%0b busy=%0b recs=%0d m10=%0d want 1 0 0 0", err_s[0], busy_s[0], rec_idx.size(), n_m10);
    end
    cfg_hang[0] = 1'b0;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    checks++;
    if (err_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
      errors++; $display("FAIL to_restart: got err=%0b busy=%0b want 0 1", err_s[0], busy_s[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    cfg_has_ref[0] = 1'b1; cfg_dist[0] = 14'h02A5; rready_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    n = 0;
    while (mode_s[0] !== 2'b10 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if (cdist_s[0] !== 14'h02A5 || busy_s[0] !== 1'b1) begin
      errors++; $display("FAIL mid_blm_state: got dist=%h busy=%0b want 02a5 1", cdist_s[0], busy_s[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs_of(0) !== '0) begin errors++; $display("FAIL mid_reset_now: got %h want 0", outs_of(0)); end
    @(negedge clk);
    checks++;
    if (outs_of(0) !== '0) begin errors++; $display("FAIL mid_reset_hold: got %h want 0", outs_of(0)); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_no_ref();
    test_sticky_bloom();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
